// File: rtl/store_commit_unit_pkg.sv
// Shared store-commit defines: op codes, IO select bits, FSM states.
package store_commit_unit_pkg;

  localparam logic [4:0] OP_SB = 5'b00000;
  localparam logic [4:0] OP_SH = 5'b00001;
  localparam logic [4:0] OP_SW = 5'b00010;

  localparam logic [1:0] IO_SEL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/store_byte_sel.sv
// Picks the byte lane for write index k and flags the final byte of the op.
module store_byte_sel
  import store_commit_unit_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] data,
  input  logic [1:0]  k,
  output logic [7:0]  sel_byte,
  output logic        last
);

  logic [1:0] last_k;

  // Unknown op codes fall back to a full word.
  always_comb begin
    last_k = 2'd3;
    unique case (1'b1)
      (op == OP_SB): last_k = 2'd0;
      (op == OP_SH): last_k = 2'd1;
      (op == OP_SW): last_k = 2'd3;
      default:       last_k = 2'd3;
    endcase
  end

  assign sel_byte = data[{k, 3'b000} +: 8];
  assign last     = (k == last_k);

endmodule

// File: rtl/store_commit_unit.sv
// Serialises one committed store into byte writes on the arbitrated port.
// STORE_FAST_ACK_EN: finish_store on the final write, no DONE cycle.
module store_commit_unit
  import store_commit_unit_pkg::*;
#(
  parameter logic [1:0] IO_SEL_HI = IO_SEL,
  parameter int         ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              store_req,
  input  logic [4:0]        store_op,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic [31:0]       store_data,
  output logic              finish_store,
  output logic              busy,
  input  logic              mem_gnt,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  input  logic              io_buffer_full
);

  state_t            state;
  logic [4:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [1:0]        k;
  logic [7:0]        sel_byte;
  logic              last;
  logic              io_stall;
  logic              wr_en;

  store_byte_sel u_sel (
    .op       (op_q),
    .data     (data_q),
    .k        (k),
    .sel_byte (sel_byte),
    .last     (last)
  );

  // UART writes wait while its buffer is full.
  assign io_stall = (addr_q[17:16] == IO_SEL_HI)
                  && io_buffer_full;

  assign wr_en = rdy && (state == ST_WRITE)
              && mem_gnt && !io_stall;

  assign mem_wr   = wr_en;
  assign mem_a    = wr_en ? addr_q + ADDR_W'(k) : '0;
  assign mem_dout = wr_en ? sel_byte : 8'h00;

`ifdef STORE_FAST_ACK_EN
  assign finish_store = wr_en && last;
`else
  logic fin_q;
  assign finish_store = fin_q && rdy;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      k       <= 2'd0;
      op_q    <= 5'd0;
      addr_q  <= '0;
      data_q  <= 32'd0;
      busy    <= 1'b0;
      mem_req <= 1'b0;
`ifndef STORE_FAST_ACK_EN
      fin_q   <= 1'b0;
`endif
    end else if (rdy) begin
      case (state)
        ST_IDLE: begin
          if (store_req) begin
            op_q    <= store_op;
            addr_q  <= store_addr;
            data_q  <= store_data;
            k       <= 2'd0;
            busy    <= 1'b1;
            mem_req <= 1'b1;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (wr_en) begin
            if (last) begin
              k       <= 2'd0;
              busy    <= 1'b0;
              mem_req <= 1'b0;
`ifdef STORE_FAST_ACK_EN
              state   <= ST_IDLE;
`else
              fin_q   <= 1'b1;
              state   <= ST_DONE;
`endif
            end else begin
              k <= k + 2'd1;
            end
          end
        end
        ST_DONE: begin
`ifndef STORE_FAST_ACK_EN
          fin_q <= 1'b0;
`endif
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_commit_unit.sv
// Directed bench for store_commit_unit with a queue-based reference model.
`timescale 1ns/1ps
module tb_store_commit_unit;
  import store_commit_unit_pkg::*;

`ifdef STORE_FAST_ACK_EN
  localparam int TAIL = 0;
`else
  localparam int TAIL = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        store_req;
  logic [4:0]  store_op;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic        finish_store;
  logic        busy;
  logic        mem_gnt;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        io_buffer_full;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  store_commit_unit dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .store_req      (store_req),
    .store_op       (store_op),
    .store_addr     (store_addr),
    .store_data     (store_data),
    .finish_store   (finish_store),
    .busy           (busy),
    .mem_gnt        (mem_gnt),
    .mem_req        (mem_req),
    .mem_wr         (mem_wr),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .io_buffer_full (io_buffer_full)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: pending byte writes of the accepted store.
  logic [31:0] q_a[$];
  logic [7:0]  q_d[$];
  bit          m_busy = 0;
  bit          m_fin = 0;
  bit          m_io = 0;
  int          acc_cyc = 0;
  int          fin_cyc = 0;
  int          fin_cnt = 0;

  // Observed writes, for the literal checks.
  int          w_cyc[$];
  logic [31:0] w_a[$];
  logic [7:0]  w_d[$];

  always @(negedge clk) begin
    bit          ew;
    bit          ef;
    logic [31:0] ea;
    logic [7:0]  ed;
    int          n;
    if (rst) begin
      q_a.delete();
      q_d.delete();
      m_busy = 0;
      m_fin = 0;
      chk("rst_ctl",
          {28'd0, finish_store, busy, mem_req, mem_wr}, 32'd0);
      chk("rst_a", mem_a, 32'd0);
      chk("rst_d", {24'd0, mem_dout}, 32'd0);
    end else begin
      ew = rdy && (q_a.size() > 0) && mem_gnt
           && !(m_io && io_buffer_full);
      ea = ew ? q_a[0] : 32'd0;
      ed = ew ? q_d[0] : 8'd0;
`ifdef STORE_FAST_ACK_EN
      ef = ew && (q_a.size() == 1);
`else
      ef = m_fin && rdy;
`endif
      chk("mem_wr", {31'd0, mem_wr}, {31'd0, ew});
      chk("mem_a", mem_a, ea);
      chk("mem_dout", {24'd0, mem_dout}, {24'd0, ed});
      chk("finish", {31'd0, finish_store}, {31'd0, ef});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("mem_req", {31'd0, mem_req},
          {31'd0, q_a.size() > 0});
      if (mem_wr) begin
        w_cyc.push_back(cyc);
        w_a.push_back(mem_a);
        w_d.push_back(mem_dout);
      end
      if (finish_store) begin
        fin_cnt++;
        fin_cyc = cyc;
      end
      if (rdy) begin
        if (m_fin) begin
          m_fin = 0;
        end else if (ew) begin
          void'(q_a.pop_front());
          void'(q_d.pop_front());
          if (q_a.size() == 0) begin
            m_busy = 0;
            m_fin = (TAIL == 1);
          end
        end else if (!m_busy && store_req) begin
          n = (store_op == OP_SB) ? 1 :
              (store_op == OP_SH) ? 2 : 4;
          for (int i = 0; i < n; i++) begin
            q_a.push_back(store_addr + 32'(i));
            q_d.push_back(8'(store_data >> (8 * i)));
          end
          m_io = (store_addr[17:16] == 2'b11);
          m_busy = 1;
          acc_cyc = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    w_cyc.delete();
    w_a.delete();
    w_d.delete();
  endtask

  task automatic issue(input logic [4:0] op,
                       input logic [31:0] a,
                       input logic [31:0] d);
    store_op = op;
    store_addr = a;
    store_data = d;
    store_req = 1'b1;
    tick();
    store_req = 1'b0;
  endtask

  task automatic wait_fin(input int base);
    int n = 0;
    while (fin_cnt == base && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (fin_cnt == base) begin
      errors++;
      $display("FAIL fin_timeout got=%0d want=%0d",
               fin_cnt, base + 1);
    end
    tick();
  endtask

  task automatic chk_w(input int i,
                       input logic [31:0] a,
                       input logic [7:0] d);
    checks++;
    if (i >= w_a.size()) begin
      errors++;
      $display("FAIL wr%0d missing got=%0d writes want>%0d",
               i, w_a.size(), i);
    end else if (w_a[i] !== a || w_d[i] !== d) begin
      errors++;
      $display("FAIL wr%0d got=%h@%h want=%h@%h",
               i, w_d[i], w_a[i], d, a);
    end
  endtask

  task automatic chk_gap(input string nm,
                         input int i, input int j,
                         input int want);
    checks++;
    if (i >= w_cyc.size() || j >= w_cyc.size()) begin
      errors++;
      $display("FAIL %s missing writes got=%0d",
               nm, w_cyc.size());
    end else if (w_cyc[j] - w_cyc[i] != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d",
               nm, w_cyc[j] - w_cyc[i], want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    rdy = 1'b1;
    store_req = 1'b0;
    store_op = 5'd0;
    store_addr = 32'd0;
    store_data = 32'd0;
    mem_gnt = 1'b0;
    io_buffer_full = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // SW, continuous grant
    clr();
    base = fin_cnt;
    mem_gnt = 1'b1;
    issue(OP_SW, 32'h0000_1000, 32'hDEAD_BEEF);
    wait_fin(base);
    chk("sw_cnt", w_a.size(), 32'd4);
    chk_w(0, 32'h1000, 8'hEF);
    chk_w(1, 32'h1001, 8'hBE);
    chk_w(2, 32'h1002, 8'hAD);
    chk_w(3, 32'h1003, 8'hDE);
    chk_gap("sw_consec", 0, 3, 3);
    chk("sw_tail", fin_cyc - w_cyc[w_cyc.size()-1], TAIL);
    chk("sw_lat", fin_cyc - acc_cyc, 4 + TAIL);

    // SB
    clr();
    base = fin_cnt;
    issue(OP_SB, 32'h0000_0203, 32'h1234_5678);
    wait_fin(base);
    chk("sb_cnt", w_a.size(), 32'd1);
    chk_w(0, 32'h203, 8'h78);
    chk("sb_lat", fin_cyc - acc_cyc, 1 + TAIL);

    // SH to IO space with a 3-cycle full buffer
    clr();
    base = fin_cnt;
    io_buffer_full = 1'b1;
    issue(OP_SH, 32'h0003_0000, 32'h0000_ABCD);
    repeat (3) tick();
    io_buffer_full = 1'b0;
    wait_fin(base);
    chk("sh_cnt", w_a.size(), 32'd2);
    chk_w(0, 32'h30000, 8'hCD);
    chk_w(1, 32'h30001, 8'hAB);
    chk("sh_stall", w_cyc[0] - acc_cyc, 4);

    // SW across the address wrap, grant toggling
    clr();
    base = fin_cnt;
    issue(OP_SW, 32'hFFFF_FFFE, 32'h1122_3344);
    for (int i = 0; i < 7; i++) begin
      mem_gnt = (i % 2 == 0);
      tick();
    end
    mem_gnt = 1'b1;
    wait_fin(base);
    chk("tg_cnt", w_a.size(), 32'd4);
    chk_w(0, 32'hFFFF_FFFE, 8'h44);
    chk_w(1, 32'hFFFF_FFFF, 8'h33);
    chk_w(2, 32'h0000_0000, 8'h22);
    chk_w(3, 32'h0000_0001, 8'h11);
    chk_gap("tg_span", 0, 3, 6);

    // Async reset after two bytes of an SW
    clr();
    base = fin_cnt;
    issue(OP_SW, 32'h0000_2000, 32'hCAFE_F00D);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_ctl",
        {28'd0, finish_store, busy, mem_req, mem_wr}, 32'd0);
    chk("ar_a", mem_a, 32'd0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("ar_wr", w_a.size(), 32'd2);
    chk("ar_fin", fin_cnt, base);
    clr();
    base = fin_cnt;
    issue(OP_SB, 32'h0000_0044, 32'h0000_0099);
    wait_fin(base);
    chk("ar_sb", w_a.size(), 32'd1);
    chk_w(0, 32'h44, 8'h99);

    // SH with requests while busy and a 2-cycle rdy drop
    clr();
    base = fin_cnt;
    issue(OP_SH, 32'h0000_0100, 32'h0000_5AA5);
    store_req = 1'b1;
    tick();
    rdy = 1'b0;
    tick();
    tick();
    rdy = 1'b1;
    tick();
    store_req = 1'b0;
    wait_fin(base);
    repeat (4) tick();
    chk("rd_cnt", w_a.size(), 32'd2);
    chk_w(0, 32'h100, 8'hA5);
    chk_w(1, 32'h101, 8'h5A);
    chk_gap("rd_pause", 0, 1, 3);
    chk("rd_fin", fin_cnt - base, 1);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_commit_unit.md
Name: store_commit_unit

Overview:
- Memory-side responder for the reorder buffer's store-commit handshake. Accepts one committed store (SB/SH/SW) with address and data, and serialises it into byte writes on the byte-wide RAM/IO port granted by the memory arbiter.
- Returns a one-cycle finish_store pulse when the last byte has been written.
- Sits between the ROB commit stage and the memory controller arbiter, alongside the instruction-fetch and load paths.

Parameters:
- IO_SEL_HI, 2'b11: value of addr[17:16] that marks a memory-mapped IO address.
- ADDR_W, 32: address width.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rdy  input  1  global ready; when low, all state is frozen
- store_req  input  1  store commit request; sampled only in IDLE
- store_op  input  5  SB/SH/SW encoding from shared defines
- store_addr  input  32  byte address of the store
- store_data  input  32  store data, little-endian
- finish_store  output  1  one-cycle completion pulse to the ROB
- busy  output  1  high from request accept until completion
- mem_gnt  input  1  arbiter grants the memory port this cycle
- mem_req  output  1  request for the memory port
- mem_wr  output  1  write strobe, one byte per cycle
- mem_a  output  32  byte address of the current write
- mem_dout  output  8  byte being written
- io_buffer_full  input  1  UART buffer full; IO writes must stall

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, byte counter k=0.
  - All outputs are 0: finish_store, busy, mem_req, mem_wr, mem_a, mem_dout.
  - A reset during WRITE aborts the store; no further bytes are written.
- rdy=0: every register holds. No write and no finish pulse occur in that cycle.
- IDLE: on store_req=1, latch op, addr and data.
  - Set len = 1 for SB, 2 for SH, 4 for SW.
  - k=0, busy=1, mem_req=1, go to WRITE.
  - Any other op value is treated as SW.
- WRITE: a byte is written in a cycle only if mem_gnt=1 and NOT (addr[17:16]==IO_SEL_HI and io_buffer_full=1).
  - In that cycle: mem_wr=1, mem_a=addr+k (32-bit wrap), mem_dout=data[8k+7:8k], then k increments.
  - In any other cycle: mem_wr=0 and all state holds.
  - After the write with k==len-1, go to DONE and drop mem_req.
- DONE: finish_store=1 for exactly one cycle, busy=0, go to IDLE.
  - Store latency with continuous grant = len+1 cycles from the accept edge to the finish pulse.
- store_req while busy is ignored; the ROB guarantees it does not issue one.
- store_req in the DONE cycle is also ignored; a new request is accepted from IDLE the next cycle.
- Rollback is not an input. A committed store always completes.
- Misaligned addresses are written byte-by-byte with no exception.
- mem_wr is never asserted without mem_gnt. mem_a and mem_dout are 0 when mem_wr=0.

Optional Feature:
- Macro: STORE_FAST_ACK_EN
- Defined: finish_store is asserted combinationally in the same cycle as the final byte write, and state returns directly to IDLE, skipping DONE. Latency = len cycles.
- Undefined: the registered DONE cycle is used as described above.

Decomposition:
- Shared defines package holds: SB/SH/SW op constants, the IO address select bits, and the state encodings (IDLE/WRITE/DONE).
- One natural sub-module: store_byte_sel. It is combinational and takes data and k, returning the selected byte and the last-byte flag (k==len-1) for a given op.

Test Plan:
- SW addr=0x00001000 data=0xDEADBEEF, mem_gnt held 1 -> writes EF@1000, BE@1001, AD@1002, DE@1003 on consecutive cycles; finish_store one cycle after the last write.
- SB addr=0x00000203 data=0x12345678 -> single write 0x78@0x203; finish_store 2 cycles after accept.
- SH addr=0x00030000 data=0xABCD with io_buffer_full=1 for 3 cycles -> no mem_wr during the stall; then CD@30000, AB@30001; finish_store follows.
- SW with mem_gnt toggling 1,0,1,0,1,0,1 -> exactly 4 writes, only in granted cycles, in address order.
- rst asserted asynchronously after the 2nd byte of an SW -> outputs 0 immediately, no finish_store; a following SB completes normally.
- store_req pulses while busy, and rdy=0 for 2 cycles mid-SH -> extra requests ignored; writes pause during rdy=0; exactly one finish_store per accepted store.
